// File: rtl/lfsr_arb_pkg.sv
// Shared types and constants for the LFSR-backed random-byte arbiter.
// Holds the FSM state enum, the Fibonacci tap mask and the reset/lock-up seed.
package lfsr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_TAPS  = 8'hB8;
    localparam logic [7:0] LFSR_RESET = 8'h01;

    // Feedback is the parity of bits 7,5,4,3, shifted in at the bottom.
    function automatic logic [7:0] lfsrNext(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] seedFix(input logic [7:0] s);
        return (s == 8'h00) ? LFSR_RESET : s;
    endfunction

endpackage

// File: rtl/lfsr_arb_rr.sv
// Two-way round-robin picker: the pointer names the preferred requester
// when both request; a lone requester always wins.
import lfsr_arb_pkg::*;

module lfsr_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_winner,
    output logic       o_any
);

    always_comb begin
        o_any = |i_req;
        if (i_req == 2'b11) begin
            o_winner = i_ptr;
        end else begin
            o_winner = i_req[1];
        end
    end

endmodule

// File: rtl/lfsr_arb.sv
// Random-byte arbiter: the LFSR advances STEPS times between grants, and the
// winner receives the LFSR state. Optional macro LFSR_ARB_FREERUN_EN lets the
// LFSR also advance in every IDLE cycle.
import lfsr_arb_pkg::*;

module lfsr_arb #(
    parameter int unsigned STEPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_we,
    input  logic [7:0] seed,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       rnd_valid,
    output logic [7:0] rnd_data,
    output logic [7:0] lfsr_bits,
    output logic       busy
);

    localparam logic [7:0] STEP_LOAD = 8'(STEPS - 1);

    state_t     r_state;
    logic [7:0] r_lfsr;
    logic [7:0] r_count;
    logic       r_ptr;
    logic       r_winner;

    logic       w_rrWinner;
    logic       w_reqAny;
    logic       w_grantHit;

    lfsr_arb_rr u_rr (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_rrWinner),
        .o_any    (w_reqAny)
    );

    // The grant is qualified by the live req and seed_we, so it decodes the
    // registered state in the same cycle rather than being pre-registered.
    assign w_grantHit = (r_state == ST_GRANT) && !seed_we && req[r_winner];
    assign gnt        = w_grantHit ? (r_winner ? 2'b10 : 2'b01) : 2'b00;
    assign rnd_valid  = w_grantHit;
    assign rnd_data   = r_lfsr;
    assign lfsr_bits  = r_lfsr;
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_lfsr   <= LFSR_RESET;
            r_count  <= 8'd0;
            r_ptr    <= 1'b0;
            r_winner <= 1'b0;
        end else if (seed_we) begin
            r_lfsr  <= seedFix(seed);
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef LFSR_ARB_FREERUN_EN
                    r_lfsr <= lfsrNext(r_lfsr);
`endif
                    if (w_reqAny) begin
                        r_winner <= w_rrWinner;
                        r_count  <= STEP_LOAD;
                        r_state  <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    r_lfsr <= lfsrNext(r_lfsr);
                    if (r_count == 8'd0) begin
                        r_state <= ST_GRANT;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                ST_GRANT: begin
                    if (req[r_winner]) begin
                        r_ptr <= ~r_winner;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lfsr_arb.md
LFSR_ARB -- requirements
Module: lfsr_arb

Interface
REQ-001 Parameter: STEPS, default 8; LFSR advances between grants; legal range 1..255.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: seed_we  input  1  load seed into the LFSR this cycle.
REQ-005 Port: seed  input  8  seed value.
REQ-006 Port: req  input  2  per-requester random-byte request; held high until granted.
REQ-007 Port: gnt  output  2  one-hot grant pulse, one cycle.
REQ-008 Port: rnd_valid  output  1  high exactly in grant cycles.
REQ-009 Port: rnd_data  output  8  equals lfsr_bits; meaningful only when rnd_valid=1.
REQ-010 Port: lfsr_bits  output  8  current LFSR state.
REQ-011 Port: busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 LFSR SHALL be 8-bit Fibonacci: fb = s[7]^s[5]^s[4]^s[3]; next = {s[6:0], fb}.
REQ-013 FSM SHALL have states IDLE, STEP, GRANT.
REQ-014 IDLE, req!=0, seed_we=0: pick winner by round-robin, latch it, load step counter with STEPS-1, go to STEP.
REQ-015 Round-robin: pointer names the preferred requester; if both request, the pointer wins; if one requests, it wins.
REQ-016 STEP: LFSR SHALL advance once per cycle; at counter==0 go to GRANT; otherwise decrement. Total advances = STEPS.
REQ-017 GRANT, latched winner's req still high: gnt[winner]=1, rnd_valid=1, pointer := other requester, go to IDLE.
REQ-018 GRANT, winner's req dropped: no gnt, no rnd_valid, pointer unchanged, go to IDLE.
REQ-019 LFSR SHALL NOT advance in IDLE or GRANT (see REQ-025 for the exception).
REQ-020 Request latency: req seen in IDLE at cycle t -> gnt at cycle t+STEPS+1. Minimum spacing between successive grants: STEPS+2 cycles.
REQ-021 seed_we has priority in every state: load seed (0 -> 8'h01, lock-up avoidance), go to IDLE, no grant this cycle, pointer unchanged.
REQ-022 seed_we together with req in IDLE: seed loads; arbitration starts the next cycle at the earliest.

Reset
REQ-023 On rst: state=IDLE, LFSR=8'h01, pointer=0, counter=0, gnt=0, rnd_valid=0, busy=0, lfsr_bits=8'h01.
REQ-024 rst asserted mid-STEP or mid-GRANT SHALL abort immediately with no gnt pulse.

Configuration
REQ-025 Macro LFSR_ARB_FREERUN_EN: when defined, the LFSR SHALL also advance every IDLE cycle without seed_we; when undefined, the LFSR is frozen in IDLE (REQ-019). STEP/GRANT behaviour is identical in both builds.

Structure
REQ-026 Package lfsr_arb_pkg SHALL hold the FSM state enum, tap-mask constant 8'hB8, and reset-state constant 8'h01.
REQ-027 Sub-module lfsr_arb_rr (2-way round-robin picker: req, pointer -> winner) is the natural split; the LFSR stays inline.

Verification (STEPS=8, LFSR_ARB_FREERUN_EN undefined)
REQ-028 Reset, then req=01 held -> gnt=01 exactly 9 cycles after the first IDLE sample, rnd_data=8'h1C (path 02,04,08,11,23,47,8E,1C).
REQ-029 Reset, then req=11 held -> first gnt=01 with 8'h1C, then gnt=10 with 8'h4B, with STEPS+2 cycles between grant pulses.
REQ-030 seed_we=1 with seed=8'h00 -> lfsr_bits=8'h01; with seed=8'h5A -> lfsr_bits=8'h5A.
REQ-031 seed_we pulsed in the 4th STEP cycle -> FSM returns to IDLE, no gnt, LFSR=seed; a held req is granted STEPS+1 cycles after re-arbitration.
REQ-032 req=01 dropped during STEP -> no gnt, no rnd_valid, pointer unchanged; rst mid-STEP -> all outputs at reset values, lfsr_bits=8'h01.
REQ-033 Build with LFSR_ARB_FREERUN_EN defined, 3 idle cycles after reset -> lfsr_bits=8'h08.
